// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with Set-2 decoding of the W/S/O/K paddle keys.
// Define PS2_KEY_ARROWS_EN to also map E0 75 / E0 72 (Up/Down) onto o_out / k_out.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w_out,
    output logic       s_out,
    output logic       o_out,
    output logic       k_out,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1_q;
    logic          clk_s2_q;
    logic          dat_s1_q;
    logic          dat_s2_q;
    logic          clk_flt_q;
    logic [FW-1:0] flt_cnt_q;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          brk_q;
    logic          ext_q;
    logic          w_q;
    logic          s_q;
    logic          o_q;
    logic          k_q;
    logic [7:0]    scan_code_q;
    logic          scan_valid_q;
    logic          frame_err_q;

    logic          fall_edge;
    logic          frame_ok;
    logic          brk_d;
    logic          ext_d;
    logic          w_d;
    logic          s_d;
    logic          o_d;
    logic          k_d;

`ifdef PS2_KEY_ARROWS_EN
    logic          up_q;
    logic          dn_q;
    logic          up_d;
    logic          dn_d;
`endif

    // Filtered clock commits a new level only after FILTER_LEN equal samples.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            clk_flt_q <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            if (clk_s2_q == clk_flt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                clk_flt_q <= clk_s2_q;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end
    end

    assign fall_edge = clk_flt_q && !clk_s2_q && (flt_cnt_q == FLT_LAST);
    assign frame_ok  = dat_s2_q && (^{shift_q, par_q});

    always_comb begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        w_d   = w_q;
        s_d   = s_q;
        o_d   = o_q;
        k_d   = k_q;
`ifdef PS2_KEY_ARROWS_EN
        up_d  = up_q;
        dn_d  = dn_q;
`endif
        if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
            brk_d = brk_q;
        end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
            ext_d = ext_q;
        end else if (!ext_q) begin
            case (shift_q)
                8'h1D:   w_d = ~brk_q;
                8'h1B:   s_d = ~brk_q;
                8'h44:   o_d = ~brk_q;
                8'h42:   k_d = ~brk_q;
                default: ;
            endcase
        end else begin
`ifdef PS2_KEY_ARROWS_EN
            case (shift_q)
                8'h75:   up_d = ~brk_q;
                8'h72:   dn_d = ~brk_q;
                default: ;
            endcase
`endif
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            w_q          <= 1'b0;
            s_q          <= 1'b0;
            o_q          <= 1'b0;
            k_q          <= 1'b0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_KEY_ARROWS_EN
            up_q         <= 1'b0;
            dn_q         <= 1'b0;
`endif
        end else begin
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall_edge) begin
                to_cnt_q <= '0;
                unique case (state_q)
                    IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (frame_ok) begin
                            scan_code_q  <= shift_q;
                            scan_valid_q <= 1'b1;
                            brk_q        <= brk_d;
                            ext_q        <= ext_d;
                            w_q          <= w_d;
                            s_q          <= s_d;
                            o_q          <= o_d;
                            k_q          <= k_d;
`ifdef PS2_KEY_ARROWS_EN
                            up_q         <= up_d;
                            dn_q         <= dn_d;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            brk_q       <= 1'b0;
                            ext_q       <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                // A stalled frame is abandoned so the next start bit resyncs.
                if (to_cnt_q == TO_LAST) begin
                    state_q     <= IDLE;
                    to_cnt_q    <= '0;
                    frame_err_q <= 1'b1;
                    brk_q       <= 1'b0;
                    ext_q       <= 1'b0;
                end else begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                end
            end
        end
    end

    assign w_out      = w_q;
    assign s_out      = s_q;
`ifdef PS2_KEY_ARROWS_EN
    assign o_out      = o_q | up_q;
    assign k_out      = k_q | dn_q;
`else
    assign o_out      = o_q;
    assign k_out      = k_q;
`endif
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;

endmodule
